// File: rtl/hist_arb_pkg.sv
// Shared types and constants for the histogram-memory arbiter and its helpers.
// Optional grant statistics are enabled in the top level by defining HIST_ARB_STATS_EN.
package hist_arb_pkg;

   localparam int N_CLI_DEF    = 2;
   localparam int CLI_ID_MAX_W = 3;
   localparam int CLI_ID_W     = $clog2(N_CLI_DEF);
   localparam int STAT_W       = 16;

   // Id field is sized for the largest supported client count (8).
   typedef struct packed {
      logic                    valid;
      logic [CLI_ID_MAX_W-1:0] id;
   } tag_t;

   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hist_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Produces a one-hot grant, the winner index and an any-request flag.
module hist_rr_pick #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      // NOTE: every output gets a default before the search loops so no path
      // leaves a value unassigned, which would otherwise infer a latch.
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!any && req[i] && (IDX_W'(i) >= ptr)) begin
            any    = 1'b1;
            gnt[i] = 1'b1;
            idx    = IDX_W'(i);
         end
      end
      // Wrap-around pass over the clients below the pointer.
      for (int i = 0; i < N; i++) begin
         if (!any && req[i] && (IDX_W'(i) < ptr)) begin
            any    = 1'b1;
            gnt[i] = 1'b1;
            idx    = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/hist_mem_arbiter.sv
// Registered round-robin arbiter for N_CLI clients sharing one histogram SRAM.
// Define HIST_ARB_STATS_EN to add per-client saturating grant counters.
module hist_mem_arbiter
   import hist_arb_pkg::*;
#(
   parameter int               N_CLI   = 2,
   parameter int               ADDR_W  = 14,
   parameter int               DATA_W  = 8,
   parameter int               RD_LAT  = 1,
   parameter logic [N_CLI-1:0] WR_MASK = 2'b01
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_CLI-1:0]          cli_req,
   input  logic [N_CLI-1:0]          cli_wen,
   input  logic [N_CLI*ADDR_W-1:0]   cli_addr,
   input  logic [N_CLI*DATA_W-1:0]   cli_wdata,
   output logic [N_CLI-1:0]          cli_gnt,
   output logic [N_CLI-1:0]          cli_rvalid,
   output logic [N_CLI*DATA_W-1:0]   cli_rdata,
   output logic                      wr_viol,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      mem_wen,
   output logic [DATA_W-1:0]         mem_wdata,
   output logic                      mem_ren,
   input  logic [DATA_W-1:0]         mem_rdata
`ifdef HIST_ARB_STATS_EN
  ,input  logic                      stat_clr,
   output logic [N_CLI*STAT_W-1:0]   stat_gnt_cnt
`endif
);

   localparam int ID_W = id_w(N_CLI);

   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   win_idx;
   logic              any_req;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic              win_wen, win_may_wr;

   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_wen_q, mem_wen_d;
   logic              mem_ren_q, mem_ren_d;
   logic              wr_viol_q, wr_viol_d;
   logic [ID_W-1:0]   cmd_id_q, cmd_id_d;

   tag_t              tag_q [RD_LAT];
   tag_t              tag_d [RD_LAT];
   tag_t              rtag;

   hist_rr_pick #(
      .N     (N_CLI),
      .IDX_W (ID_W)
   ) u_pick (
      .req (cli_req),
      .ptr (rr_ptr_q),
      .gnt (cli_gnt),
      .idx (win_idx),
      .any (any_req)
   );

   // One-hot grant selects the winner's command fields by AND-OR muxing.
   always_comb begin
      win_addr   = '0;
      win_wdata  = '0;
      win_wen    = 1'b0;
      win_may_wr = 1'b0;
      for (int i = 0; i < N_CLI; i++) begin
         if (cli_gnt[i]) begin
            win_addr   = win_addr  | cli_addr[i*ADDR_W +: ADDR_W];
            win_wdata  = win_wdata | cli_wdata[i*DATA_W +: DATA_W];
            win_wen    = win_wen   | cli_wen[i];
            win_may_wr = win_may_wr | WR_MASK[i];
         end
      end
   end

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cmd_id_d    = cmd_id_q;
      mem_wen_d   = 1'b0;
      mem_ren_d   = 1'b0;
      wr_viol_d   = 1'b0;
      if (any_req) begin
         rr_ptr_d    = (win_idx == ID_W'(N_CLI - 1)) ? '0 : win_idx + ID_W'(1);
         mem_addr_d  = win_addr;
         mem_wdata_d = win_wdata;
         cmd_id_d    = win_idx;
         mem_wen_d   = win_wen & win_may_wr;
         mem_ren_d   = ~win_wen;
         wr_viol_d   = win_wen & ~win_may_wr;
      end
   end

   // Tag enters the pipe one cycle after mem_ren is launched, so the last
   // stage lines up with the SRAM data RD_LAT cycles after mem_ren.
   always_comb begin
      for (int i = 0; i < RD_LAT; i++) begin
         tag_d[i] = '0;
      end
      tag_d[0].valid = mem_ren_q;
      tag_d[0].id    = CLI_ID_MAX_W'(cmd_id_q);
      for (int i = 1; i < RD_LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wen_q   <= 1'b0;
         mem_ren_q   <= 1'b0;
         wr_viol_q   <= 1'b0;
         cmd_id_q    <= '0;
         // NOTE: the tag pipe is reset like any other control flop (it is not
         // a storage array), which is what drops in-flight reads on reset.
         for (int i = 0; i < RD_LAT; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wen_q   <= mem_wen_d;
         mem_ren_q   <= mem_ren_d;
         wr_viol_q   <= wr_viol_d;
         cmd_id_q    <= cmd_id_d;
         for (int i = 0; i < RD_LAT; i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

   assign rtag = tag_q[RD_LAT-1];

   always_comb begin
      cli_rvalid = '0;
      cli_rdata  = '0;
      for (int i = 0; i < N_CLI; i++) begin
         if (rtag.valid && (rtag.id == CLI_ID_MAX_W'(i))) begin
            cli_rvalid[i]                  = 1'b1;
            cli_rdata[i*DATA_W +: DATA_W]  = mem_rdata;
         end
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wen   = mem_wen_q;
   assign mem_ren   = mem_ren_q;
   assign wr_viol   = wr_viol_q;

`ifdef HIST_ARB_STATS_EN
   logic [STAT_W-1:0] stat_cnt_q [N_CLI];
   logic [STAT_W-1:0] stat_cnt_d [N_CLI];

   // Clear has priority over a same-cycle grant; counters stick at all-ones.
   always_comb begin
      for (int i = 0; i < N_CLI; i++) begin
         stat_cnt_d[i] = stat_cnt_q[i];
         if (stat_clr) begin
            stat_cnt_d[i] = '0;
         end else if (cli_gnt[i] && (stat_cnt_q[i] != {STAT_W{1'b1}})) begin
            stat_cnt_d[i] = stat_cnt_q[i] + STAT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CLI; i++) begin
            stat_cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CLI; i++) begin
            stat_cnt_q[i] <= stat_cnt_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_CLI; i++) begin
         stat_gnt_cnt[i*STAT_W +: STAT_W] = stat_cnt_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_hist_mem_arbiter.sv
// Directed bench for hist_mem_arbiter: one RD_LAT=1 instance with an SRAM model
// and one RD_LAT=3 instance for latency and reset-drop checks.
`timescale 1ns/1ps
module tb_hist_mem_arbiter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // RD_LAT = 1 instance
   logic        rst_n;
   logic [1:0]  cli_req, cli_wen, cli_gnt, cli_rvalid;
   logic [27:0] cli_addr;
   logic [15:0] cli_wdata, cli_rdata;
   logic        wr_viol, mem_wen, mem_ren;
   logic [13:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;

   // RD_LAT = 3 instance
   logic        rst3_n;
   logic [1:0]  req3, wen3, gnt3, rvalid3;
   logic [27:0] addr3;
   logic [15:0] wdata3, rdata3;
   logic        viol3, mem_wen3, mem_ren3;
   logic [13:0] mem_addr3;
   logic [7:0]  mem_wdata3;
   logic [7:0]  mem_rdata3;
   assign mem_rdata3 = 8'h5A;

`ifdef HIST_ARB_STATS_EN
   logic        stat_clr, stat_clr3;
   logic [31:0] stat_cnt, stat_cnt3;
`endif

   hist_mem_arbiter #(.N_CLI(2), .ADDR_W(14), .DATA_W(8), .RD_LAT(1), .WR_MASK(2'b01)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cli_req    (cli_req),
      .cli_wen    (cli_wen),
      .cli_addr   (cli_addr),
      .cli_wdata  (cli_wdata),
      .cli_gnt    (cli_gnt),
      .cli_rvalid (cli_rvalid),
      .cli_rdata  (cli_rdata),
      .wr_viol    (wr_viol),
      .mem_addr   (mem_addr),
      .mem_wen    (mem_wen),
      .mem_wdata  (mem_wdata),
      .mem_ren    (mem_ren),
      .mem_rdata  (mem_rdata)
`ifdef HIST_ARB_STATS_EN
     ,.stat_clr     (stat_clr),
      .stat_gnt_cnt (stat_cnt)
`endif
   );

   hist_mem_arbiter #(.N_CLI(2), .ADDR_W(14), .DATA_W(8), .RD_LAT(3), .WR_MASK(2'b01)) dut3 (
      .clk        (clk),
      .rst_n      (rst3_n),
      .cli_req    (req3),
      .cli_wen    (wen3),
      .cli_addr   (addr3),
      .cli_wdata  (wdata3),
      .cli_gnt    (gnt3),
      .cli_rvalid (rvalid3),
      .cli_rdata  (rdata3),
      .wr_viol    (viol3),
      .mem_addr   (mem_addr3),
      .mem_wen    (mem_wen3),
      .mem_wdata  (mem_wdata3),
      .mem_ren    (mem_ren3),
      .mem_rdata  (mem_rdata3)
`ifdef HIST_ARB_STATS_EN
     ,.stat_clr     (stat_clr3),
      .stat_gnt_cnt (stat_cnt3)
`endif
   );

   // SRAM model with one cycle of read latency.
   logic [7:0] model_mem [0:16383];
   always @(posedge clk) begin
      if (mem_wen) model_mem[mem_addr] <= mem_wdata;
      if (mem_ren) mem_rdata <= model_mem[mem_addr];
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rst3_n = 1'b0;
      cli_req = '0; cli_wen = '0; cli_addr = '0; cli_wdata = '0;
      req3 = '0; wen3 = '0; addr3 = '0; wdata3 = '0;
`ifdef HIST_ARB_STATS_EN
      stat_clr = 1'b0; stat_clr3 = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1; rst3_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_checks++;
         if ({mem_addr, mem_wdata, mem_wen, mem_ren, wr_viol} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_mem cyc%0d: addr=%h wdata=%h wen=%b ren=%b viol=%b, want all 0",
                     k, mem_addr, mem_wdata, mem_wen, mem_ren, wr_viol);
         end
         n_checks++;
         if ({cli_gnt, cli_rvalid, cli_rdata} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_cli cyc%0d: gnt=%b rvalid=%b rdata=%h, want 0", k, cli_gnt, cli_rvalid, cli_rdata);
         end
         n_checks++;
         if ({gnt3, rvalid3, mem_ren3} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_dut3 cyc%0d: gnt=%b rvalid=%b ren=%b, want 0", k, gnt3, rvalid3, mem_ren3);
         end
      end
`ifdef HIST_ARB_STATS_EN
      n_checks++;
      if (stat_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_stats: got %h want 0", stat_cnt);
      end
`endif
   endtask

   task automatic test_write();
      next_cycle();
      cli_req = 2'b01; cli_wen = 2'b01; cli_addr[13:0] = 14'h0123; cli_wdata[7:0] = 8'hA5;
      @(negedge clk);
      n_checks++;
      if (cli_gnt !== 2'b01) begin
         n_fail++;
         $display("FAIL wr_gnt: got %b want 01", cli_gnt);
      end
      next_cycle();
      cli_req = '0; cli_wen = '0;
      @(negedge clk);
      n_checks++;
      if ({mem_wen, mem_ren, wr_viol, mem_addr, mem_wdata} !== {3'b100, 14'h0123, 8'hA5}) begin
         n_fail++;
         $display("FAIL wr_cmd: wen=%b ren=%b viol=%b addr=%h wdata=%h, want 1 0 0 0123 a5",
                  mem_wen, mem_ren, wr_viol, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_read();
      next_cycle();
      cli_req = 2'b10; cli_wen = 2'b00; cli_addr[27:14] = 14'h0123;
      @(negedge clk);
      n_checks++;
      if (cli_gnt !== 2'b10) begin
         n_fail++;
         $display("FAIL rd_gnt: got %b want 10", cli_gnt);
      end
      next_cycle();
      cli_req = '0;
      @(negedge clk);
      n_checks++;
      if ({mem_ren, mem_wen, mem_addr, cli_rvalid} !== {2'b10, 14'h0123, 2'b00}) begin
         n_fail++;
         $display("FAIL rd_cmd: ren=%b wen=%b addr=%h rvalid=%b, want 1 0 0123 00",
                  mem_ren, mem_wen, mem_addr, cli_rvalid);
      end
      @(negedge clk);
      n_checks++;
      if ({cli_rvalid, cli_rdata} !== {2'b10, 16'hA500}) begin
         n_fail++;
         $display("FAIL rd_ret: rvalid=%b rdata=%h, want 10 a500", cli_rvalid, cli_rdata);
      end
      @(negedge clk);
      n_checks++;
      if ({cli_rvalid, cli_rdata} !== 18'd0) begin
         n_fail++;
         $display("FAIL rd_ret_end: rvalid=%b rdata=%h, want 00 0000", cli_rvalid, cli_rdata);
      end
   endtask

   task automatic test_round_robin();
      int g0, g1;
      logic [1:0] exp_g;
      g0 = 0; g1 = 0;
      next_cycle();
      cli_req = 2'b11; cli_wen = 2'b00;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         g0 += int'(cli_gnt[0]);
         g1 += int'(cli_gnt[1]);
         n_checks++;
         if (cli_gnt !== exp_g) begin
            n_fail++;
            $display("FAIL rr_gnt cyc%0d: got %b want %b", k, cli_gnt, exp_g);
         end
         if (k >= 2) begin
            n_checks++;
            if (cli_rvalid !== exp_g) begin
               n_fail++;
               $display("FAIL rr_order cyc%0d: rvalid=%b want %b", k, cli_rvalid, exp_g);
            end
         end
         next_cycle();
      end
      cli_req = '0;
      n_checks++;
      if (g0 != 4 || g1 != 4) begin
         n_fail++;
         $display("FAIL rr_fair: grants %0d/%0d want 4/4", g0, g1);
      end
      repeat (3) next_cycle();
   endtask

   task automatic test_wr_viol();
      cli_req = 2'b10; cli_wen = 2'b10; cli_addr[27:14] = 14'h2AAA; cli_wdata[15:8] = 8'h77;
      @(negedge clk);
      n_checks++;
      if (cli_gnt !== 2'b10) begin
         n_fail++;
         $display("FAIL viol_gnt: got %b want 10", cli_gnt);
      end
      next_cycle();
      cli_req = '0; cli_wen = '0;
      @(negedge clk);
      n_checks++;
      if ({mem_wen, mem_ren, wr_viol} !== 3'b001) begin
         n_fail++;
         $display("FAIL viol_cmd: wen=%b ren=%b viol=%b, want 0 0 1", mem_wen, mem_ren, wr_viol);
      end
      @(negedge clk);
      n_checks++;
      if ({wr_viol, mem_addr} !== {1'b0, 14'h2AAA}) begin
         n_fail++;
         $display("FAIL viol_end: viol=%b addr=%h, want 0 2aaa", wr_viol, mem_addr);
      end
   endtask

   task automatic test_back_to_back();
      next_cycle();
      cli_req = 2'b01; cli_wen = 2'b01; cli_addr[13:0] = 14'h0010; cli_wdata[7:0] = 8'h11;
      @(negedge clk);
      n_checks++;
      if (cli_gnt !== 2'b01) begin
         n_fail++;
         $display("FAIL b2b_wgnt: got %b want 01", cli_gnt);
      end
      next_cycle();
      cli_addr[13:0] = 14'h3FFF; cli_wdata[7:0] = 8'h22;
      @(negedge clk);
      n_checks++;
      if ({cli_gnt, mem_wen, mem_addr, mem_wdata} !== {2'b01, 1'b1, 14'h0010, 8'h11}) begin
         n_fail++;
         $display("FAIL b2b_w1: gnt=%b wen=%b addr=%h wdata=%h, want 01 1 0010 11",
                  cli_gnt, mem_wen, mem_addr, mem_wdata);
      end
      next_cycle();
      cli_req = '0; cli_wen = '0;
      @(negedge clk);
      n_checks++;
      if ({mem_wen, mem_addr, mem_wdata} !== {1'b1, 14'h3FFF, 8'h22}) begin
         n_fail++;
         $display("FAIL b2b_w2: wen=%b addr=%h wdata=%h, want 1 3fff 22", mem_wen, mem_addr, mem_wdata);
      end
      next_cycle();
      cli_req = 2'b11; cli_addr = {14'h3FFF, 14'h0010};
      @(negedge clk);
      n_checks++;
      if (cli_gnt !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_rgnt1: got %b want 10", cli_gnt);
      end
      next_cycle();
      cli_req = 2'b01;
      @(negedge clk);
      n_checks++;
      if ({cli_gnt, mem_ren, mem_addr} !== {2'b01, 1'b1, 14'h3FFF}) begin
         n_fail++;
         $display("FAIL b2b_rgnt2: gnt=%b ren=%b addr=%h, want 01 1 3fff", cli_gnt, mem_ren, mem_addr);
      end
      next_cycle();
      cli_req = '0;
      @(negedge clk);
      n_checks++;
      if ({cli_rvalid, cli_rdata, mem_addr} !== {2'b10, 16'h2200, 14'h0010}) begin
         n_fail++;
         $display("FAIL b2b_ret1: rvalid=%b rdata=%h addr=%h, want 10 2200 0010", cli_rvalid, cli_rdata, mem_addr);
      end
      @(negedge clk);
      n_checks++;
      if ({cli_rvalid, cli_rdata} !== {2'b01, 16'h0011}) begin
         n_fail++;
         $display("FAIL b2b_ret2: rvalid=%b rdata=%h, want 01 0011", cli_rvalid, cli_rdata);
      end
      @(negedge clk);
      n_checks++;
      if ({cli_rvalid, mem_ren, mem_addr} !== {3'b000, 14'h0010}) begin
         n_fail++;
         $display("FAIL b2b_idle: rvalid=%b ren=%b addr=%h, want 00 0 0010", cli_rvalid, mem_ren, mem_addr);
      end
   endtask

   task automatic test_rd_lat3();
      logic [1:0] exp_v;
      next_cycle();
      req3 = 2'b10; wen3 = 2'b00; addr3[27:14] = 14'h0100;
      @(negedge clk);
      n_checks++;
      if (gnt3 !== 2'b10) begin
         n_fail++;
         $display("FAIL lat3_gnt: got %b want 10", gnt3);
      end
      next_cycle();
      req3 = '0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         exp_v = (k == 4) ? 2'b10 : 2'b00;
         n_checks++;
         if ({rvalid3, rdata3} !== {exp_v, (k == 4) ? 16'h5A00 : 16'h0000}) begin
            n_fail++;
            $display("FAIL lat3_ret t+%0d: rvalid=%b rdata=%h want %b", k, rvalid3, rdata3, exp_v);
         end
      end
   endtask

   task automatic test_reset_inflight();
      next_cycle();
      req3 = 2'b01; wen3 = 2'b00;
      @(negedge clk);
      n_checks++;
      if (gnt3 !== 2'b01) begin
         n_fail++;
         $display("FAIL rstfl_gnt: got %b want 01", gnt3);
      end
      next_cycle();
      req3 = '0;
      @(negedge clk);
      n_checks++;
      if (mem_ren3 !== 1'b1) begin
         n_fail++;
         $display("FAIL rstfl_ren: got %b want 1", mem_ren3);
      end
      #2 rst3_n = 1'b0;
      #1;
      n_checks++;
      if ({mem_ren3, rvalid3} !== 3'b000) begin
         n_fail++;
         $display("FAIL rstfl_async: ren=%b rvalid=%b want 0 00", mem_ren3, rvalid3);
      end
      @(posedge clk);
      next_cycle();
      rst3_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_checks++;
         if (rvalid3 !== 2'b00) begin
            n_fail++;
            $display("FAIL rstfl_drop cyc%0d: rvalid=%b want 00", k, rvalid3);
         end
      end
   endtask

`ifdef HIST_ARB_STATS_EN
   task automatic test_stats();
      // Grants so far: client0 = 1 + 4 + 3 = 8, client1 = 1 + 4 + 1 + 1 = 7.
      @(negedge clk);
      n_checks++;
      if (stat_cnt !== {16'd7, 16'd8}) begin
         n_fail++;
         $display("FAIL stat_count: got %h want 00070008", stat_cnt);
      end
      next_cycle();
      stat_clr = 1'b1; cli_req = 2'b01; cli_wen = 2'b00;
      next_cycle();
      stat_clr = 1'b0; cli_req = '0;
      @(negedge clk);
      n_checks++;
      if (stat_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL stat_clr_wins: got %h want 0", stat_cnt);
      end
      next_cycle();
      cli_req = 2'b01;
      repeat (65540) @(posedge clk);
      #1 cli_req = '0;
      @(negedge clk);
      n_checks++;
      if (stat_cnt !== {16'h0000, 16'hFFFF}) begin
         n_fail++;
         $display("FAIL stat_sat: got %h want 0000ffff", stat_cnt);
      end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_round_robin();
      test_wr_viol();
      test_back_to_back();
      test_rd_lat3();
      test_reset_inflight();
`ifdef HIST_ARB_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hist_mem_arbiter.md
Name: hist_mem_arbiter

Overview:
- Parametrised, registered arbiter granting N_CLI clients access to one single-port histogram SRAM; next generation of the fixed two-way HCU/DCU histogram-memory select.
- Replaces the external static select with per-cycle round-robin arbitration, per-client write permission and tagged read-data return.
- Sits between histogram compute/display units and the histogram SRAM macro.

Parameters:
- N_CLI, 2, number of clients (2..8)
- ADDR_W, 14, memory address width
- DATA_W, 8, memory data width
- RD_LAT, 1, SRAM read latency in cycles, counted from the cycle mem_ren is high (1..4)
- WR_MASK, 2'b01, bit i = 1 means client i may write; client 0 is the HCU

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cli_req  in  N_CLI  access request per client; held until granted
- cli_wen  in  N_CLI  1 = write, 0 = read; qualified by cli_req
- cli_addr  in  N_CLI*ADDR_W  packed addresses; client i occupies bits [i*ADDR_W +: ADDR_W]
- cli_wdata  in  N_CLI*DATA_W  packed write data
- cli_gnt  out  N_CLI  one-hot acceptance, combinational, same cycle as the accepted request
- cli_rvalid  out  N_CLI  one-hot read-return strobe
- cli_rdata  out  N_CLI*DATA_W  read data; slice is zero unless that client's rvalid is high
- wr_viol  out  1  one-cycle pulse: a write from a client without write permission was granted
- mem_addr  out  ADDR_W  SRAM address, registered
- mem_wen  out  1  SRAM write enable, registered
- mem_wdata  out  DATA_W  SRAM write data, registered
- mem_ren  out  1  SRAM read enable, registered
- mem_rdata  in  DATA_W  SRAM read data

Behaviour:
- Reset: mem_addr=0, mem_wen=0, mem_wdata=0, mem_ren=0, wr_viol=0, rr_ptr=0, tag pipeline cleared. cli_rvalid=0 and cli_rdata=0 follow from the cleared pipeline.
- Arbitration: each cycle, pick the first requesting client at or after rr_ptr, wrapping modulo N_CLI.
  - cli_gnt[w]=1 for the winner only; cli_gnt=0 when there is no request.
  - After a grant to w, rr_ptr <= (w+1) mod N_CLI. rr_ptr holds when idle.
- Command, cycle t+1 after a grant at t: mem_addr/mem_wdata get the winner's address/data.
  - mem_wen = winner wen AND WR_MASK[w].
  - mem_ren = NOT winner wen.
  - No grant: mem_wen=mem_ren=0; mem_addr/mem_wdata hold their last value.
- Write violation: winner wen=1 with WR_MASK[w]=0. Still granted (the request is consumed), mem_wen=mem_ren=0, wr_viol=1 at t+1.
- Read return: a tag shift register (valid + client id, RD_LAT stages) is loaded when mem_ren is issued.
  - At t+1+RD_LAT: cli_rvalid[id]=1 and that client's slice = mem_rdata (combinational from mem_rdata). All other slices are 0.
- Throughput: one access per cycle. Back-to-back reads from different clients return in issue order.
- Fairness: with all clients requesting continuously, each is granted once per N_CLI cycles.
- Client request sampled on the same cycle as its own rvalid: legal and independent.
- Reset mid-operation: in-flight reads are dropped, with no rvalid after reset release.

Optional Feature:
- Macro HIST_ARB_STATS_EN.
- Defined:
  - Adds input stat_clr (1) and output stat_gnt_cnt (N_CLI*16).
  - One 16-bit saturating grant counter per client, reset to 0 and synchronously cleared by stat_clr. stat_clr wins over a same-cycle increment.
  - A counter holds at 16'hFFFF.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package hist_arb_pkg holds:
  - CLI_ID_W = $clog2(N_CLI) default helper
  - the tag struct/typedef {valid, id}
  - the STAT_W=16 constant
- One sub-module is natural: hist_rr_pick (combinational round-robin priority picker: req vector + pointer -> one-hot grant + index). Reused by other shared-memory arbiters.

Test Plan:
- Reset release, no requests -> all mem_* 0, cli_gnt=0, cli_rvalid=0 for 10 cycles.
- Client 0 writes addr 14'h0123, data 8'hA5 -> cli_gnt=2'b01 same cycle; next cycle mem_wen=1, mem_addr=14'h0123, mem_wdata=8'hA5.
- Client 1 reads 14'h0123 with the model returning 8'hA5, RD_LAT=1 -> cli_rvalid=2'b10 two cycles after grant, cli_rdata[15:8]=8'hA5, cli_rdata[7:0]=0.
- Both clients request continuously for 8 cycles -> grants alternate 01,10,01,...; 4 grants each.
- Client 1 issues a write -> granted, mem_wen=0, mem_ren=0, wr_viol=1 for exactly one cycle.
- Reads in flight with RD_LAT=3, rst_n pulsed low -> no cli_rvalid after release. With HIST_ARB_STATS_EN: counters read 0 after reset and saturate at 16'hFFFF in a forced long run.
